mem_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the pipeline's instruction fetch (F stage) and data access (M stage).
- Serialises the two into single-outstanding transactions. Data requests have priority over instruction requests.
- Raises per-requester stall signals, which feed the hazard unit's stallF/stallM generation.
- Sits between the mips core and the external memory or cache bridge.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_timeout.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state/source encodings and the data-strobe helper for the memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } arb_src_t;

    // A store wins over a load when both enable sets are nonzero.
    function automatic logic [3:0] dataStrobe(input logic [3:0] ren, input logic [3:0] wen);
        return (wen != 4'd0) ? wen : ren;
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Transaction watchdog for the memory bus arbiter; only built when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_active,
    output logic o_expire,
    output logic o_timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;
    logic          r_timeoutErr;

    // Fires on the edge that completes the TIMEOUT_CYCLES-th cycle spent in ADDR/RESP.
    assign o_expire      = i_active && (r_count == CW'(TIMEOUT_CYCLES - 1));
    assign o_timeout_err = r_timeoutErr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            if (i_start) begin
                r_count <= '0;
            end else if (i_active && !o_expire) begin
                r_count <= r_count + CW'(1);
            end
            if (o_expire) begin
                r_timeoutErr <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Serialises F-stage fetches and M-stage data accesses onto one memory port, data first.
// Define MEM_ARB_TIMEOUT_EN to add the transaction watchdog and the timeout_err port.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_stall,
    input  logic [3:0]  data_ren,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_stall,
    input  logic        pipe_adv,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        busy
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    arb_state_t  r_state;
    arb_src_t    r_curSrc;
    logic        r_instDone;
    logic        r_dataDone;
    logic [31:0] r_instHold;
    logic [31:0] r_dataHold;
    logic [31:0] r_reqAddr;
    logic [31:0] r_reqWdata;
    logic        r_reqWr;
    logic [3:0]  r_reqWstrb;

    logic w_dataNeed;
    logic w_instNeed;
    logic w_complete;
    logic w_completeInst;
    logic w_completeData;
    logic w_start;
    logic w_expire;
    logic w_timeout;

    assign w_dataNeed     = ((data_ren != 4'd0) || (data_wen != 4'd0)) && !r_dataDone;
    assign w_instNeed     = inst_req && !r_instDone;
    assign w_complete     = (r_state == RESP) && mem_data_ok;
    assign w_completeData = w_complete && (r_curSrc == SRC_DATA);
    assign w_completeInst = w_complete && (r_curSrc == SRC_INST);
    assign w_start        = (r_state == IDLE) && !w_timeout && (w_dataNeed || w_instNeed);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_active     (r_state != IDLE),
        .o_expire     (w_expire),
        .o_timeout_err(timeout_err)
    );
    assign w_timeout = timeout_err;
`else
    assign w_expire  = 1'b0;
    assign w_timeout = 1'b0;
`endif

    assign mem_req   = (r_state == ADDR);
    assign busy      = (r_state != IDLE);
    assign mem_addr  = r_reqAddr;
    assign mem_wr    = r_reqWr;
    assign mem_wstrb = r_reqWstrb;
    assign mem_wdata = r_reqWdata;

    // A completing result is forwarded in its own cycle so the stage can advance without waiting a cycle.
    assign data_stall = (w_dataNeed && !w_completeData) || w_timeout;
    assign inst_stall = (w_instNeed && !w_completeInst) || w_timeout;
    assign data_rdata = w_completeData ? mem_rdata : r_dataHold;
    assign inst_rdata = w_completeInst ? mem_rdata : r_instHold;

    // Transaction FSM; pipe_adv is applied last so its clear overrides a same-cycle done set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_curSrc   <= SRC_INST;
            r_instDone <= 1'b0;
            r_dataDone <= 1'b0;
            r_instHold <= '0;
            r_dataHold <= '0;
            r_reqAddr  <= '0;
            r_reqWdata <= '0;
            r_reqWr    <= 1'b0;
            r_reqWstrb <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start && w_dataNeed) begin
                        r_reqAddr  <= data_addr;
                        r_reqWr    <= (data_wen != 4'd0);
                        r_reqWstrb <= dataStrobe(data_ren, data_wen);
                        r_reqWdata <= data_wdata;
                        r_curSrc   <= SRC_DATA;
                        r_state    <= ADDR;
                    end else if (w_start) begin
                        r_reqAddr  <= inst_addr;
                        r_reqWr    <= 1'b0;
                        r_reqWstrb <= 4'd0;
                        r_reqWdata <= '0;
                        r_curSrc   <= SRC_INST;
                        r_state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_expire) begin
                        r_state <= IDLE;
                    end else if (mem_addr_ok) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (w_expire) begin
                        r_state <= IDLE;
                    end else if (mem_data_ok) begin
                        r_state <= IDLE;
                        if (r_curSrc == SRC_DATA) begin
                            r_dataDone <= 1'b1;
                            if (!r_reqWr) begin
                                r_dataHold <= mem_rdata;
                            end
                        end else if (inst_req) begin
                            // A fetch flushed while in flight is simply dropped here.
                            r_instDone <= 1'b1;
                            r_instHold <= mem_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (pipe_adv) begin
                r_instDone <= 1'b0;
                r_dataDone <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model with a randomised memory responder.
// Exercises the watchdog as well when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    localparam int TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_stall;
    logic [3:0]  data_ren;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_stall;
    logic        pipe_adv;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] expInstHold = '0;
    logic [31:0] expDataHold = '0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        bit          isData;
    } txn_t;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
        .data_ren(data_ren), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_stall(data_stall), .pipe_adv(pipe_adv),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1; inst_req = 0; inst_addr = '0; data_ren = 0; data_wen = 0; data_addr = '0; data_wdata = '0;
        pipe_adv = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (inst_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_stall: got %b expected 0", inst_stall); end
        checks++; if (data_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_stall: got %b expected 0", data_stall); end
        checks++; if (inst_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_rdata: got %h expected 0", inst_rdata); end
        checks++; if (data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_rdata: got %h expected 0", data_rdata); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if ({mem_wr, mem_wstrb} !== 5'h0) begin errors++; $display("[TB] FAIL reset_mem_wr_wstrb: got %b expected 0", {mem_wr, mem_wstrb}); end
        inst_req = 1; data_ren = 4'h3;
        #1;
        checks++; if (inst_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_inst_stall_comb: got %b expected 1", inst_stall); end
        checks++; if (data_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_data_stall_comb: got %b expected 1", data_stall); end
        inst_req = 0; data_ren = 0; rst = 0;
        expInstHold = '0; expDataHold = '0;
    endtask

    // One pipeline "step": both requesters present their requests until served, then pipe_adv consumes them.
    task automatic runRound(input logic iReq, input logic [31:0] iAddr, input logic [3:0] ren, input logic [3:0] wen,
                            input logic [31:0] dAddr, input logic [31:0] wdata, input int addrDly, input int dataDly,
                            input int holdCycles, input bit useFixed, input logic [31:0] fixedVal, input string tag);
        txn_t q[$];
        txn_t t;
        bit dataPend;
        bit instPend;
        bit completing;
        int phase;
        int cnt;
        int cyc;
        logic [31:0] rv;
        @(negedge clk);
        inst_req = iReq; inst_addr = iAddr; data_ren = ren; data_wen = wen; data_addr = dAddr; data_wdata = wdata;
        pipe_adv = 0;
        dataPend = (ren != 4'd0) || (wen != 4'd0);
        instPend = iReq;
        if (dataPend) begin
            t.addr = dAddr; t.wr = (wen != 4'd0); t.strb = (wen != 4'd0) ? wen : ren; t.wdata = wdata; t.isData = 1;
            q.push_back(t);
        end
        if (instPend) begin
            t.addr = iAddr; t.wr = 0; t.strb = 4'd0; t.wdata = '0; t.isData = 0;
            q.push_back(t);
        end
        phase = 0; cnt = 0; cyc = 0;
        while ((q.size() != 0) && (cyc < 40)) begin
            mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = $urandom; completing = 0;
            if (phase == 0 && mem_req === 1'b1) begin
                checks++; if (mem_addr !== q[0].addr) begin errors++; $display("[TB] FAIL %s_mem_addr: got %h expected %h", tag, mem_addr, q[0].addr); end
                checks++; if (mem_wr !== q[0].wr) begin errors++; $display("[TB] FAIL %s_mem_wr: got %b expected %b", tag, mem_wr, q[0].wr); end
                checks++; if (mem_wstrb !== q[0].strb) begin errors++; $display("[TB] FAIL %s_mem_wstrb: got %b expected %b", tag, mem_wstrb, q[0].strb); end
                if (q[0].wr) begin
                    checks++; if (mem_wdata !== q[0].wdata) begin errors++; $display("[TB] FAIL %s_mem_wdata: got %h expected %h", tag, mem_wdata, q[0].wdata); end
                end
                phase = 1; cnt = addrDly;
            end
            if (phase == 1) begin
                checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL %s_req_held: got %b expected 1", tag, mem_req); end
                if (cnt == 0) begin mem_addr_ok = 1; phase = 2; cnt = dataDly; end
                else cnt--;
            end else if (phase == 2) begin
                checks++; if ({mem_req, busy} !== 2'b01) begin errors++; $display("[TB] FAIL %s_resp_phase: got req,busy=%b expected 01", tag, {mem_req, busy}); end
                cnt--;
                if (cnt <= 0) begin
                    mem_data_ok = 1; completing = 1;
                    if (useFixed) mem_rdata = fixedVal;
                end
            end
            rv = mem_rdata;
            #1;
            if (completing) begin
                t = q.pop_front();
                if (t.isData) begin
                    dataPend = 0;
                    if (!t.wr) begin
                        checks++; if (data_rdata !== rv) begin errors++; $display("[TB] FAIL %s_data_fwd: got %h expected %h", tag, data_rdata, rv); end
                        expDataHold = rv;
                    end
                end else begin
                    instPend = 0;
                    checks++; if (inst_rdata !== rv) begin errors++; $display("[TB] FAIL %s_inst_fwd: got %h expected %h", tag, inst_rdata, rv); end
                    expInstHold = rv;
                end
                phase = 0;
            end
            checks++; if (data_stall !== dataPend) begin errors++; $display("[TB] FAIL %s_data_stall: got %b expected %b", tag, data_stall, dataPend); end
            checks++; if (inst_stall !== instPend) begin errors++; $display("[TB] FAIL %s_inst_stall: got %b expected %b", tag, inst_stall, instPend); end
            @(negedge clk);
            cyc++;
        end
        mem_addr_ok = 0; mem_data_ok = 0;
        checks++; if (q.size() != 0) begin errors++; $display("[TB] FAIL %s_round_timeout: got %0d pending expected 0", tag, q.size()); end
        // Results must sit in the hold registers with no re-issue until the pipeline advances.
        for (int h = 0; h <= holdCycles; h++) begin
            mem_rdata = $urandom;
            #1;
            checks++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("[TB] FAIL %s_hold_idle: got req,busy=%b expected 00", tag, {mem_req, busy}); end
            checks++; if ({data_stall, inst_stall} !== 2'b00) begin errors++; $display("[TB] FAIL %s_hold_stalls: got %b expected 00", tag, {data_stall, inst_stall}); end
            checks++; if (data_rdata !== expDataHold) begin errors++; $display("[TB] FAIL %s_data_hold: got %h expected %h", tag, data_rdata, expDataHold); end
            checks++; if (inst_rdata !== expInstHold) begin errors++; $display("[TB] FAIL %s_inst_hold: got %h expected %h", tag, inst_rdata, expInstHold); end
            @(negedge clk);
        end
        pipe_adv = 1;
        @(negedge clk);
        pipe_adv = 0; inst_req = 0; data_ren = 0; data_wen = 0;
    endtask

    task automatic test_fetch_only();
        runRound(1, 32'hBFC0_0000, 4'h0, 4'h0, '0, '0, 0, 2, 1, 1, 32'h2408_0001, "fetch");
        checks++; if (expInstHold !== 32'h2408_0001) begin errors++; $display("[TB] FAIL fetch_value: got %h expected 24080001", expInstHold); end
    endtask

    task automatic test_priority();
        runRound(1, 32'hBFC0_0004, 4'hF, 4'h0, 32'h8000_0010, '0, 1, 1, 0, 0, '0, "prio");
    endtask

    task automatic test_byte_store();
        runRound(0, '0, 4'h0, 4'b0100, 32'h8000_0020, 32'h00AB_0000, 0, 1, 1, 0, '0, "store");
    endtask

    task automatic test_done_hold();
        runRound(1, 32'hBFC0_0008, 4'b0011, 4'h0, 32'h8000_0030, '0, 0, 3, 3, 0, '0, "hold");
        runRound(0, '0, 4'hF, 4'h0, 32'h8000_0034, '0, 0, 1, 0, 0, '0, "reload");
    endtask

    task automatic test_reset_mid_resp();
        int cyc = 0;
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h8000_0100; data_ren = 0; data_wen = 0;
        while (mem_req !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL midresp_issue: got %b expected 1", mem_req); end
        mem_addr_ok = 1;
        @(negedge clk);
        mem_addr_ok = 0;
        checks++; if ({mem_req, busy} !== 2'b01) begin errors++; $display("[TB] FAIL midresp_in_resp: got req,busy=%b expected 01", {mem_req, busy}); end
        rst = 1;
        @(negedge clk);
        rst = 0; inst_req = 0; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("[TB] FAIL midresp_after_rst: got req,busy=%b expected 00", {mem_req, busy}); end
        checks++; if (inst_rdata !== 32'h0) begin errors++; $display("[TB] FAIL midresp_stray_fwd: got %h expected 0", inst_rdata); end
        @(negedge clk);
        mem_data_ok = 0; inst_req = 1; data_ren = 4'hF;
        #1;
        checks++; if (inst_rdata !== 32'h0) begin errors++; $display("[TB] FAIL midresp_inst_hold: got %h expected 0", inst_rdata); end
        checks++; if (data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL midresp_data_hold: got %h expected 0", data_rdata); end
        checks++; if ({data_stall, inst_stall} !== 2'b11) begin errors++; $display("[TB] FAIL midresp_no_done: got %b expected 11", {data_stall, inst_stall}); end
        rst = 1;
        @(negedge clk);
        rst = 0; inst_req = 0; data_ren = 0;
        expInstHold = '0; expDataHold = '0;
    endtask

    task automatic test_random();
        logic [3:0] ren;
        logic [3:0] wen;
        int op;
        for (int r = 0; r < 30; r++) begin
            op = $urandom_range(0, 2);
            ren = 4'd0; wen = 4'd0;
            if (op == 1) ren = 4'($urandom_range(1, 15));
            if (op == 2) begin wen = 4'($urandom_range(1, 15)); ren = 4'($urandom_range(0, 15)); end
            runRound(($urandom_range(0, 3) != 0), $urandom, ren, wen, $urandom, $urandom,
                     $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2), 0, '0, "rand");
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int entry = -1;
        int first = -1;
        @(negedge clk);
        inst_req = 1; inst_addr = 32'hBFC0_0100;
        for (int n = 0; n < TB_TIMEOUT + 30; n++) begin
            mem_addr_ok = 0;
            if (entry < 0 && mem_req === 1'b1) begin entry = n; mem_addr_ok = 1; end
            if (first < 0 && timeout_err === 1'b1) first = n;
            @(negedge clk);
        end
        mem_addr_ok = 0;
        checks++; if (entry < 0) begin errors++; $display("[TB] FAIL timeout_issue: got no request expected one"); end
        checks++; if (first - entry !== TB_TIMEOUT) begin errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", first - entry, TB_TIMEOUT); end
        #1;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_err); end
        checks++; if ({busy, data_stall, inst_stall} !== 3'b011) begin errors++; $display("[TB] FAIL timeout_state: got busy,dstall,istall=%b expected 011", {busy, data_stall, inst_stall}); end
        rst = 1;
        @(negedge clk);
        rst = 0; inst_req = 0;
        #1;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: got %b expected 0", timeout_err); end
        expInstHold = '0; expDataHold = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_only();
        test_priority();
        test_byte_store();
        test_done_hold();
        test_reset_mid_resp();
        test_random();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
